bmem_responder: RTL and testbench

BMEM_RESPONDER -- requirements
Module: bmem_responder

---
 rtl/bmem_responder.sv | 197 +++++++++++++++++++
 tb/tb_bmem_responder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmem_responder.sv
// bmem_responder: line-oriented memory model with a 4-beat write burst port
// and a fixed-latency, in-order read-return path. Reads snapshot the whole
// line at acceptance and queue it until its countdown expires.
module bmem_responder #(
  parameter int LATENCY   = 8,
  parameter int QDEPTH    = 4,
  parameter int MEM_LINES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bmem_addr,
  input  logic        bmem_read,
  input  logic        bmem_write,
  input  logic [63:0] bmem_wdata,
  output logic        bmem_ready,
  output logic [31:0] bmem_raddr,
  output logic [63:0] bmem_rdata,
  output logic        bmem_rvalid
);

  localparam int LIW = $clog2(MEM_LINES);
  localparam int QAW = $clog2(QDEPTH);
  localparam int CW  = $clog2(LATENCY);
  localparam logic [CW-1:0]  CD_INIT = CW'(LATENCY - 1);
  localparam logic [QAW:0]   QFULL   = (QAW + 1)'(QDEPTH);

  typedef enum logic {W_IDLE, W_BURST} wstate_t;
  typedef enum logic {R_IDLE, R_BURST} rstate_t;

  // write path
  wstate_t          r_wstate, w_wstate_next;
  logic [1:0]       r_wcnt, w_wcnt_next;
  logic [LIW-1:0]   r_widx;
  logic [191:0]     r_wbeats;
  logic             w_wr_acc, w_rd_acc, w_commit;

  // storage
  logic [255:0]     r_mem [MEM_LINES];
  logic [255:0]     w_snap;

  // read queue
  logic [31:0]      r_q_addr [QDEPTH];
  logic [255:0]     r_q_line [QDEPTH];
  logic [CW-1:0]    r_q_cd   [QDEPTH];
  logic [QAW-1:0]   r_head, r_tail;
  logic [QAW:0]     r_count;
  logic             w_pop, w_head_ready;

  // return path
  rstate_t          r_rstate, w_rstate_next;
  logic [1:0]       r_rbeat, w_rbeat_next;
  logic [1:0]       w_obeat;

  // Write FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wstate <= W_IDLE;
      r_wcnt   <= 2'd0;
    end else begin
      r_wstate <= w_wstate_next;
      r_wcnt   <= w_wcnt_next;
    end
  end

  // Write FSM next state: beat 0 opens a burst, beat 3 closes it, idle cycles stall
  always_comb begin
    w_wstate_next = r_wstate;
    w_wcnt_next   = r_wcnt;
    case (r_wstate)
      W_IDLE: begin
        if (w_wr_acc) begin
          w_wstate_next = W_BURST;
          w_wcnt_next   = 2'd1;
        end
      end
      W_BURST: begin
        if (bmem_write) begin
          if (r_wcnt == 2'd3) begin
            w_wstate_next = W_IDLE;
            w_wcnt_next   = 2'd0;
          end else begin
            w_wcnt_next = r_wcnt + 2'd1;
          end
        end
      end
      default: ;
    endcase
  end

  // Write FSM outputs: ready depends on state and queue occupancy, never on read/write
  always_comb begin
    bmem_ready = !rst && ((r_wstate == W_BURST) || (r_count < QFULL));
    w_wr_acc   = bmem_ready && bmem_write;
    w_rd_acc   = bmem_ready && bmem_read && !bmem_write && (r_wstate == W_IDLE);
    w_commit   = (r_wstate == W_BURST) && bmem_write && (r_wcnt == 2'd3);
  end

  // Capture line index on beat 0 and the first three beats of the burst
  always_ff @(posedge clk) begin
    if (r_wstate == W_IDLE && w_wr_acc) begin
      r_widx          <= bmem_addr[LIW+4:5];
      r_wbeats[63:0]  <= bmem_wdata;
    end else if (r_wstate == W_BURST && bmem_write && r_wcnt != 2'd3) begin
      r_wbeats[{r_wcnt, 6'd0} +: 64] <= bmem_wdata;
    end
  end

  // Line storage: commit the full line with beat 3; contents survive reset
  always_ff @(posedge clk) begin
    if (w_commit && !rst)
      r_mem[r_widx] <= {bmem_wdata, r_wbeats};
  end

  // A read can only be accepted in W_IDLE, never on a commit edge, so the
  // plain array read already reflects every completed write.
  assign w_snap = r_mem[bmem_addr[LIW+4:5]];

  // Queue pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_rd_acc) r_tail <= r_tail + QAW'(1);
      if (w_pop)    r_head <= r_head + QAW'(1);
      case ({w_rd_acc, w_pop})
        2'b10:   r_count <= r_count + (QAW + 1)'(1);
        2'b01:   r_count <= r_count - (QAW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue entries: load on push, otherwise every countdown saturates down to 0
  always_ff @(posedge clk) begin
    for (int i = 0; i < QDEPTH; i++) begin
      if (w_rd_acc && r_tail == QAW'(i)) begin
        r_q_addr[i] <= bmem_addr & ~32'h1F;
        r_q_line[i] <= w_snap;
        r_q_cd[i]   <= CD_INIT;
      end else if (r_q_cd[i] != '0) begin
        r_q_cd[i] <= r_q_cd[i] - CW'(1);
      end
    end
  end

  assign w_head_ready = (r_count != '0) && (r_q_cd[r_head] == '0);

  // Return FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rstate <= R_IDLE;
      r_rbeat  <= 2'd0;
    end else begin
      r_rstate <= w_rstate_next;
      r_rbeat  <= w_rbeat_next;
    end
  end

  // Return FSM next state: beat 0 is emitted from R_IDLE, beats 1..3 from R_BURST
  always_comb begin
    w_rstate_next = r_rstate;
    w_rbeat_next  = r_rbeat;
    case (r_rstate)
      R_IDLE: begin
        if (w_head_ready) begin
          w_rstate_next = R_BURST;
          w_rbeat_next  = 2'd1;
        end
      end
      R_BURST: begin
        if (r_rbeat == 2'd3) begin
          w_rstate_next = R_IDLE;
          w_rbeat_next  = 2'd0;
        end else begin
          w_rbeat_next = r_rbeat + 2'd1;
        end
      end
      default: ;
    endcase
  end

  // Return FSM outputs: data and address are forced to zero outside a beat
  always_comb begin
    bmem_rvalid = (r_rstate == R_BURST) || w_head_ready;
    w_obeat     = (r_rstate == R_BURST) ? r_rbeat : 2'd0;
    w_pop       = (r_rstate == R_BURST) && (r_rbeat == 2'd3);
    bmem_rdata  = '0;
    bmem_raddr  = '0;
    if (bmem_rvalid) begin
      bmem_rdata = r_q_line[r_head][{w_obeat, 6'd0} +: 64];
      bmem_raddr = r_q_addr[r_head];
    end
  end

endmodule

// File: tb/tb_bmem_responder.sv
// Testbench for bmem_responder: table of write/read vectors plus hand-written
// multi-cycle sequences; read beats are checked against a scoreboard queue.
module tb_bmem_responder;

  localparam int LAT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] bmem_addr = '0;
  logic        bmem_read = 1'b0;
  logic        bmem_write = 1'b0;
  logic [63:0] bmem_wdata = '0;
  logic        bmem_ready;
  logic [31:0] bmem_raddr;
  logic [63:0] bmem_rdata;
  logic        bmem_rvalid;

  bmem_responder #(.LATENCY(LAT), .QDEPTH(4), .MEM_LINES(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .bmem_addr  (bmem_addr),
    .bmem_read  (bmem_read),
    .bmem_write (bmem_write),
    .bmem_wdata (bmem_wdata),
    .bmem_ready (bmem_ready),
    .bmem_raddr (bmem_raddr),
    .bmem_rdata (bmem_rdata),
    .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          cyc;
    logic [31:0] raddr;
    logic [63:0] rdata;
  } beat_t;

  beat_t sb[$];
  int    sb_last = -100;
  bit    mon_en = 1'b0;

  typedef struct {
    logic [31:0]  waddr;
    logic [255:0] wline;
    logic [31:0]  raddr;
    logic [31:0]  exp_raddr;
    logic [255:0] exp_line;
  } vec_t;

  vec_t vt[5];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compare every returned beat with the scoreboard head
  always @(negedge clk) begin
    beat_t b;
    if (mon_en && !rst) begin
      if (bmem_rvalid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got raddr %h rdata %h want no beat (cyc %0d)",
                   bmem_raddr, bmem_rdata, cyc);
        end else begin
          b = sb.pop_front();
          check("beat_cycle", 64'(cyc), 64'(b.cyc));
          check("beat_raddr", 64'(bmem_raddr), 64'(b.raddr));
          check("beat_rdata", bmem_rdata, b.rdata);
          $display("beat cyc=%0d raddr=%h rdata=%h", cyc, bmem_raddr, bmem_rdata);
        end
      end else begin
        check("idle_rdata", bmem_rdata, 64'd0);
        check("idle_raddr", 64'(bmem_raddr), 64'd0);
        if (sb.size() != 0 && sb[0].cyc <= cyc) begin
          b = sb.pop_front();
          n_cmp++;
          n_bad++;
          $display("FAIL missed_beat: got rvalid 0 want beat raddr %h rdata %h (cyc %0d)",
                   b.raddr, b.rdata, cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_read(input logic [31:0] exp_raddr, input logic [255:0] line);
    beat_t b;
    int first;
    first = (cyc + LAT > sb_last + 1) ? cyc + LAT : sb_last + 1;
    for (int k = 0; k < 4; k++) begin
      b.cyc   = first + k;
      b.raddr = exp_raddr;
      b.rdata = line[64*k +: 64];
      sb.push_back(b);
    end
    sb_last = first + 3;
  endtask

  task automatic do_read(input logic [31:0] a, input logic exp_rdy,
                         input logic [31:0] exp_raddr, input logic [255:0] line);
    bmem_addr = a;
    bmem_read = 1'b1;
    @(negedge clk);
    check("read_ready", 64'(bmem_ready), 64'(exp_rdy));
    if (exp_rdy) push_read(exp_raddr, line);
    $display("read addr=%h ready=%0b cyc=%0d", a, bmem_ready, cyc);
    step();
    bmem_read = 1'b0;
  endtask

  task automatic write_line(input logic [31:0] a, input logic [255:0] line,
                            input int gap, input bit probe, input bit rd_w0);
    bmem_write = 1'b1;
    bmem_addr  = a;
    bmem_wdata = line[63:0];
    bmem_read  = rd_w0;
    @(negedge clk);
    check("write_ready", 64'(bmem_ready), 64'd1);
    step();
    bmem_read = 1'b0;
    for (int k = 1; k < 4; k++) begin
      if (k == 2) begin
        for (int g = 0; g < gap; g++) begin
          bmem_write = 1'b0;
          bmem_read  = probe;
          bmem_addr  = a;
          @(negedge clk);
          check("stall_ready", 64'(bmem_ready), 64'd1);
          step();
        end
        bmem_read = 1'b0;
      end
      bmem_write = 1'b1;
      bmem_addr  = 32'hDEAD_BEE0;
      bmem_wdata = line[64*k +: 64];
      step();
    end
    bmem_write = 1'b0;
    bmem_addr  = '0;
    $display("write addr=%h line=%h", a, line);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      step();
      n++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d beats pending want 0", sb.size());
      sb.delete();
    end
    repeat (4) step();
  endtask

  function automatic logic [255:0] mk(input logic [31:0] tag);
    return {tag, 32'h0000_0003, tag, 32'h0000_0002, tag, 32'h0000_0001, tag, 32'h0000_0000};
  endfunction

  initial begin
    int t0;
    logic [255:0] l1, l5, l6;

    l1 = {64'hA4A4_0000_0000_00A4, 64'hA3A3_0000_0000_00A3,
          64'hA2A2_0000_0000_00A2, 64'hA1A1_0000_0000_00A1};

    vt[0].waddr = 32'h0000_0040;
    vt[0].wline = {64'h44, 64'h33, 64'h22, 64'h11};
    vt[0].raddr = 32'h0000_0040; vt[0].exp_raddr = 32'h0000_0040;
    vt[0].exp_line = {64'h44, 64'h33, 64'h22, 64'h11};

    vt[1].waddr = 32'h0000_2040; vt[1].wline = l1;
    vt[1].raddr = 32'h0000_0040; vt[1].exp_raddr = 32'h0000_0040;
    vt[1].exp_line = l1;

    vt[2].waddr = 32'h001F_FFE5;
    vt[2].wline = {64'hFFFF_0000_FFFF_0000, 64'h0123_4567_89AB_CDEF,
                   64'h8000_0000_0000_0001, 64'hFEDC_BA98_7654_3210};
    vt[2].raddr = 32'h0000_FFE0; vt[2].exp_raddr = 32'h0000_FFE0;
    vt[2].exp_line = vt[2].wline;

    vt[3].waddr = 32'h0000_0000; vt[3].wline = mk(32'h5A5A_0000);
    vt[3].raddr = 32'h0000_001F; vt[3].exp_raddr = 32'h0000_0000;
    vt[3].exp_line = mk(32'h5A5A_0000);

    vt[4].waddr = 32'h0000_0080; vt[4].wline = mk(32'h0BAD_CAFE);
    vt[4].raddr = 32'hABC0_0093; vt[4].exp_raddr = 32'hABC0_0080;
    vt[4].exp_line = mk(32'h0BAD_CAFE);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready",  64'(bmem_ready),  64'd0);
    check("rst_rvalid", 64'(bmem_rvalid), 64'd0);
    check("rst_rdata",  bmem_rdata,       64'd0);
    check("rst_raddr",  64'(bmem_raddr),  64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(bmem_ready), 64'd1);
    mon_en = 1'b1;
    step();

    // Table-driven write/read vectors
    for (int i = 0; i < 5; i++) begin
      write_line(vt[i].waddr, vt[i].wline, 0, 1'b0, 1'b0);
      do_read(vt[i].raddr, 1'b1, vt[i].exp_raddr, vt[i].exp_line);
      wait_drain();
    end

    // Queue full with four back-to-back reads
    for (int i = 0; i < 4; i++)
      write_line(32'h100 + 32'(i * 32), mk(32'hC0DE_0000 + 32'(i)), 0, 1'b0, 1'b0);
    t0 = cyc;
    for (int i = 0; i < 4; i++)
      do_read(32'h100 + 32'(i * 32), 1'b1, 32'h100 + 32'(i * 32), mk(32'hC0DE_0000 + 32'(i)));
    do_read(32'h100, 1'b0, 32'h100, mk(32'hC0DE_0000));
    while (cyc < t0 + LAT + 4) begin
      @(negedge clk);
      check("full_ready_low", 64'(bmem_ready), 64'd0);
      step();
    end
    @(negedge clk);
    check("full_ready_back", 64'(bmem_ready), 64'd1);
    step();
    wait_drain();

    // Stalled write with ignored probe reads in the gap
    l5 = mk(32'h5555_0300);
    write_line(32'h300, l5, 2, 1'b1, 1'b0);
    do_read(32'h300, 1'b1, 32'h300, l5);
    wait_drain();

    // Read and write together in W_IDLE: write wins, read dropped
    l6 = mk(32'h6666_0340);
    write_line(32'h340, l6, 0, 1'b0, 1'b1);
    repeat (14) step();
    do_read(32'h340, 1'b1, 32'h340, l6);
    wait_drain();

    // Reset during beat 2 of a read burst
    t0 = cyc;
    do_read(32'h40, 1'b1, 32'h40, l1);
    while (cyc < t0 + LAT + 2) step();
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("midrst_rvalid", 64'(bmem_rvalid), 64'd0);
    check("midrst_rdata",  bmem_rdata,       64'd0);
    check("midrst_ready",  64'(bmem_ready),  64'd0);
    step();
    rst = 1'b0;
    sb_last = -100;
    repeat (15) step();
    do_read(32'h40, 1'b1, 32'h40, l1);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
